// File: rtl/booth_mul_sched.sv
// Shared iterative radix-2 Booth multiplier with a round-robin front end for two
// requesters and a valid/ready result port. One operation in flight at a time.
module booth_mul_sched #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_product,
    output logic                 busy
);

    localparam int AW = 2*WIDTH + 2;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic              last_grant, grant_id, grant;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH:0]    a_ext, upper_sum;
    logic [AW-1:0]     acc, acc_step;
    logic [CW-1:0]     cnt;
    logic              run_last;

    // Both valid: alternate away from whoever was served last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else if (req1_valid)
            grant = 1'b1;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid &&  grant;
    assign rsp_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign run_last   = (cnt == CW'(WIDTH-1));

    // Booth step: inspect {b_i, b_(i-1)}, add/subtract into the upper part, then
    // arithmetic shift the whole accumulator right by one.
    assign a_ext = {a_q[WIDTH-1], a_q};
    always_comb begin
        upper_sum = acc[AW-1:WIDTH+1];
        case (acc[1:0])
            2'b01:   upper_sum = acc[AW-1:WIDTH+1] + a_ext;
            2'b10:   upper_sum = acc[AW-1:WIDTH+1] - a_ext;
            default: upper_sum = acc[AW-1:WIDTH+1];
        endcase
        acc_step = {upper_sum[WIDTH], upper_sum, acc[WIDTH:1]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0_ready || req1_ready) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (run_last) state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant  <= 1'b1;
            grant_id    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc         <= '0;
            cnt         <= '0;
            rsp_product <= '0;
            rsp_id      <= 1'b0;
        end else begin
            if (req1_ready) begin
                a_q        <= req1_a;
                b_q        <= req1_b;
                grant_id   <= 1'b1;
                last_grant <= 1'b1;
            end else if (req0_ready) begin
                a_q        <= req0_a;
                b_q        <= req0_b;
                grant_id   <= 1'b0;
                last_grant <= 1'b0;
            end

            if (state == LOAD) begin
                acc <= {{(WIDTH+1){1'b0}}, b_q, 1'b0};
                cnt <= '0;
            end else if (state == RUN) begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
                // Result registers persist after the handshake; only rsp_valid qualifies them.
                if (run_last) begin
                    rsp_product <= acc_step[2*WIDTH:1];
                    rsp_id      <= grant_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed and exhaustive bench for booth_mul_sched at WIDTH=4: arbitration,
// latency, backpressure hold, async reset abort and all 256 operand pairs.
module tb_booth_mul_sched;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [2*W-1:0] rsp_product;

    int checks   = 0;
    int failures = 0;

    booth_mul_sched #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Issue one request alone from an idle DUT, then drain the response.
    task automatic run_op(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_p, input int idle_pre, input int bp,
                          input string tag);
        int n;
        repeat (idle_pre) tick();
        if (who) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        #1;
        check({tag, "_ready"}, who ? req1_ready : req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(n);
        check({tag, "_latency"}, n, 5);
        repeat (bp) tick();
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_product"}, rsp_product, exp_p);
        check({tag, "_id"}, rsp_id, who);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_drop"}, rsp_valid, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n, hits;
        logic [2*W-1:0] exp_p;

        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        do_reset();

        check("rst_valid", rsp_valid, 0);
        check("rst_id", rsp_id, 0);
        check("rst_product", rsp_product, 0);
        check("rst_busy", busy, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);

        // 1: 3 * -2 = -6
        run_op(1'b0, 4'd3, 4'hE, 8'hFA, 0, 0, "t1");

        // 2: contention right after reset -> req0 first, then req1, then req0 again
        do_reset();
        req0_valid = 1; req0_a = 4'h8; req0_b = 4'h8;
        req1_valid = 1; req1_a = 4'd7; req1_b = 4'd5;
        #1;
        check("t2_first_r0", req0_ready, 1);
        check("t2_first_r1", req1_ready, 0);
        tick();
        req0_valid = 0;
        check("t2_load_r1", req1_ready, 0);
        wait_rsp(n);
        check("t2_lat0", n, 5);
        check("t2_prod0", rsp_product, 8'h40);
        check("t2_id0", rsp_id, 0);
        rsp_ready = 1; tick(); rsp_ready = 0;
        check("t2_second_r1", req1_ready, 1);
        tick();
        req1_valid = 0;
        wait_rsp(n);
        check("t2_lat1", n, 5);
        check("t2_prod1", rsp_product, 8'h23);
        check("t2_id1", rsp_id, 1);
        rsp_ready = 1; tick(); rsp_ready = 0;
        req0_valid = 1; req1_valid = 1;
        #1;
        check("t2_third_r0", req0_ready, 1);
        check("t2_third_r1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        #1;

        // 3: boundary operands
        run_op(1'b1, 4'h8, 4'd7, 8'hC8, 1, 0, "t3a");
        run_op(1'b0, 4'd0, 4'h8, 8'h00, 0, 1, "t3b");
        run_op(1'b1, 4'hF, 4'hF, 8'h01, 0, 0, "t3c");

        // 4: backpressure in DONE for 5 cycles with both requesters pushing
        req1_valid = 1; req1_a = 4'd2; req1_b = 4'd3;
        tick();
        req1_valid = 0;
        wait_rsp(n);
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 5; i++) begin
            check("t4_valid", rsp_valid, 1);
            check("t4_product", rsp_product, 8'h06);
            check("t4_id", rsp_id, 1);
            check("t4_r0", req0_ready, 0);
            check("t4_r1", req1_ready, 0);
            check("t4_busy", busy, 1);
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        rsp_ready = 1; tick(); rsp_ready = 0;
        check("t4_drop", rsp_valid, 0);
        check("t4_idle", busy, 0);

        // 5: async reset during RUN discards the operation
        req0_valid = 1; req0_a = 4'd5; req0_b = 4'd3;
        tick();
        req0_valid = 0;
        repeat (3) tick();
        #2 rst = 1;
        #1;
        check("t5_busy", busy, 0);
        check("t5_valid", rsp_valid, 0);
        check("t5_product", rsp_product, 0);
        check("t5_id", rsp_id, 0);
        check("t5_r0", req0_ready, 0);
        #3 rst = 0;
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rsp_valid) hits++;
        end
        check("t5_no_rsp", hits, 0);
        run_op(1'b0, 4'd5, 4'd3, 8'h0F, 0, 0, "t5_after");

        // 6: all operand pairs, random requester, idle gaps and backpressure
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                exp_p = 8'(int'($signed(4'(ai))) * int'($signed(4'(bi))));
                run_op(1'($urandom_range(1, 0)), 4'(ai), 4'(bi), exp_p,
                       $urandom_range(2, 0), $urandom_range(3, 0), "ex");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
